// File: rtl/laser_pkg.sv
// laser_pkg: shared types and sizing for the LASER pattern driver.
// Holds the FSM state enum, the point record and the default geometry.
package laser_pkg;

    localparam int NUM_PTS   = 40;                     // points per pattern
    localparam int COORD_W   = 4;                      // coordinate width
    localparam int RADIUS_SQ = 16;                     // coverage threshold (inclusive)
    localparam int IDX_W     = $clog2(NUM_PTS);        // pattern index / load address width
    localparam int CNT_W     = $clog2(NUM_PTS + 1);    // covered-point count width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_SCORE,
        ST_REPORT
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

endpackage

// File: rtl/laser_pattern_driver_if.sv
// laser_pattern_driver_if: host load bus, engine stream/result and status
// signals of the pattern driver. The driver itself uses the slave modport;
// the host/engine side (or a bench) uses master.
interface laser_pattern_driver_if;
    import laser_pkg::*;

    // host pattern load and run control
    logic                 LD_VALID;
    logic [IDX_W-1:0]     LD_ADDR;
    logic [COORD_W-1:0]   LD_X;
    logic [COORD_W-1:0]   LD_Y;
    logic                 START;

    // point stream towards the engine
    logic [COORD_W-1:0]   X;
    logic [COORD_W-1:0]   Y;

    // engine answer
    logic                 DONE;
    logic [COORD_W-1:0]   C1X;
    logic [COORD_W-1:0]   C1Y;
    logic [COORD_W-1:0]   C2X;
    logic [COORD_W-1:0]   C2Y;

    // status and result
    logic                 BUSY;
    logic                 RESULT_VALID;
    logic [CNT_W-1:0]     COVER_CNT;
    logic                 TIMEOUT;
    logic [COORD_W-1:0]   CAP_C1X;
    logic [COORD_W-1:0]   CAP_C1Y;
    logic [COORD_W-1:0]   CAP_C2X;
    logic [COORD_W-1:0]   CAP_C2Y;

    modport master (
        output LD_VALID, LD_ADDR, LD_X, LD_Y, START,
        output DONE, C1X, C1Y, C2X, C2Y,
        input  X, Y, BUSY, RESULT_VALID, COVER_CNT, TIMEOUT,
        input  CAP_C1X, CAP_C1Y, CAP_C2X, CAP_C2Y
    );

    modport slave (
        input  LD_VALID, LD_ADDR, LD_X, LD_Y, START,
        input  DONE, C1X, C1Y, C2X, C2Y,
        output X, Y, BUSY, RESULT_VALID, COVER_CNT, TIMEOUT,
        output CAP_C1X, CAP_C1Y, CAP_C2X, CAP_C2Y
    );

endinterface

// File: rtl/laser_cover_chk.sv
// laser_cover_chk: combinational coverage test of one pattern point against
// two circle centres. Covered when dx*dx + dy*dy <= COVER_RSQ for either
// centre; a point inside both still yields a single covered bit.
module laser_cover_chk
    import laser_pkg::*;
#(
    parameter int COVER_RSQ = laser_pkg::RADIUS_SQ
) (
    input  point_t i_pt,
    input  point_t i_c1,
    input  point_t i_c2,
    output logic   o_covered
);

    localparam int SQ_W  = 2 * COORD_W;   // a 4-bit difference squared fits in 8 bits
    localparam int SUM_W = SQ_W + 1;      // sum of two squares needs one more bit

    logic [1:0] w_hit;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ctr
        point_t             w_c;
        logic [COORD_W-1:0] w_dx;
        logic [COORD_W-1:0] w_dy;
        logic [SQ_W-1:0]    w_dx_sq;
        logic [SQ_W-1:0]    w_dy_sq;
        logic [SUM_W-1:0]   w_sum;

        assign w_c     = (gi == 0) ? i_c1 : i_c2;
        // absolute differences stay unsigned and 4 bits wide
        assign w_dx    = (i_pt.x >= w_c.x) ? (i_pt.x - w_c.x) : (w_c.x - i_pt.x);
        assign w_dy    = (i_pt.y >= w_c.y) ? (i_pt.y - w_c.y) : (w_c.y - i_pt.y);
        assign w_dx_sq = {{COORD_W{1'b0}}, w_dx} * {{COORD_W{1'b0}}, w_dx};
        assign w_dy_sq = {{COORD_W{1'b0}}, w_dy} * {{COORD_W{1'b0}}, w_dy};
        assign w_sum   = {1'b0, w_dx_sq} + {1'b0, w_dy_sq};
        assign w_hit[gi] = (w_sum <= SUM_W'(COVER_RSQ));
    end

    assign o_covered = |w_hit;

endmodule

// File: rtl/laser_pattern_driver.sv
// laser_pattern_driver: holds a host-loaded pattern, streams it to the LASER
// engine one point per cycle, waits for a fresh DONE, captures the two circle
// centres and (with LASER_DRV_SCORE_EN defined) counts the covered points.
// Without LASER_DRV_SCORE_EN the run ends straight after capture and
// COVER_CNT stays 0; the captured centres are then the only result.
module laser_pattern_driver
    import laser_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   CLK,
    input  logic                   RST,
    laser_pattern_driver_if.slave  bus
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    point_t             r_mem [NUM_PTS];
    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic               r_armed;
    logic               r_timeout;
    point_t             r_out_pt;
    point_t             r_c1;
    point_t             r_c2;

    logic               w_ld_ok;
    logic               w_start;
    logic               w_last_idx;
    logic               w_capture;
    logic               w_wait_expired;
    logic [IDX_W-1:0]   w_rd_addr;
    point_t             w_rd_pt;

    assign w_ld_ok        = (r_state == ST_IDLE) && bus.LD_VALID && (bus.LD_ADDR < IDX_W'(NUM_PTS));
    assign w_start        = (r_state == ST_IDLE) && bus.START;
    assign w_last_idx     = (r_idx == IDX_W'(NUM_PTS - 1));
    // stale DONE from the previous run is ignored until it has been seen low
    assign w_capture      = (r_state == ST_WAIT) && r_armed && bus.DONE;
    assign w_wait_expired = (r_state == ST_WAIT) && !w_capture
                            && (r_wait_cnt == WCNT_W'(TIMEOUT_CYC - 1));

    // Read address runs one ahead of the point being used so that the
    // registered read presents mem[k] in cycle k of SEND/SCORE.
    assign w_rd_addr = ((r_state == ST_SEND || r_state == ST_SCORE) && !w_last_idx)
                       ? (r_idx + 1'b1) : '0;

    // A load in the START cycle must be visible to the first SEND point.
    assign w_rd_pt = (w_ld_ok && (bus.LD_ADDR == w_rd_addr))
                     ? '{x: bus.LD_X, y: bus.LD_Y} : r_mem[w_rd_addr];

    // Pattern memory write port: host loads only while idle, never reset.
    always_ff @(posedge CLK) begin
        if (w_ld_ok) begin
            r_mem[bus.LD_ADDR] <= '{x: bus.LD_X, y: bus.LD_Y};
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.START) w_state_next = ST_SEND;
            ST_SEND:   if (w_last_idx) w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_capture) begin
`ifdef LASER_DRV_SCORE_EN
                    w_state_next = ST_SCORE;
`else
                    w_state_next = ST_REPORT;
`endif
                end else if (w_wait_expired) begin
                    w_state_next = ST_REPORT;
                end
            end
            ST_SCORE:  if (w_last_idx) w_state_next = ST_REPORT;
            ST_REPORT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Outgoing point register: mem[k] in SEND cycle k, zero at all other times.
    always_ff @(posedge CLK) begin
        if (RST)                            r_out_pt <= '0;
        else if (w_state_next == ST_SEND)   r_out_pt <= w_rd_pt;
        else                                r_out_pt <= '0;
    end

    // Sequencing: point index, WAIT counter, DONE arming, timeout flag, capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_armed    <= 1'b0;
            r_timeout  <= 1'b0;
            r_c1       <= '0;
            r_c2       <= '0;
        end else begin
            if (w_state_next != r_state)                         r_idx <= '0;
            else if (r_state == ST_SEND || r_state == ST_SCORE)  r_idx <= r_idx + 1'b1;

            if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                    r_wait_cnt <= '0;

            if (r_state != ST_WAIT) r_armed <= 1'b0;
            else if (!bus.DONE)     r_armed <= 1'b1;

            if (w_start)             r_timeout <= 1'b0;
            else if (w_wait_expired) r_timeout <= 1'b1;

            if (w_capture) begin
                r_c1 <= '{x: bus.C1X, y: bus.C1Y};
                r_c2 <= '{x: bus.C2X, y: bus.C2Y};
            end
        end
    end

`ifdef LASER_DRV_SCORE_EN
    point_t           r_sc_pt;
    logic [CNT_W-1:0] r_cover_cnt;
    logic             w_covered;

    laser_cover_chk #(
        .COVER_RSQ (RADIUS_SQ)
    ) u_cover_chk (
        .i_pt      (r_sc_pt),
        .i_c1      (r_c1),
        .i_c2      (r_c2),
        .o_covered (w_covered)
    );

    // Scoring: registered read of the point under test and the covered count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sc_pt     <= '0;
            r_cover_cnt <= '0;
        end else begin
            r_sc_pt <= w_rd_pt;
            if (w_start || w_wait_expired)                r_cover_cnt <= '0;
            else if (r_state == ST_SCORE && w_covered)    r_cover_cnt <= r_cover_cnt + 1'b1;
        end
    end

    assign bus.COVER_CNT = r_cover_cnt;
`else
    assign bus.COVER_CNT = '0;
`endif

    assign bus.X            = r_out_pt.x;
    assign bus.Y            = r_out_pt.y;
    assign bus.BUSY         = (r_state != ST_IDLE);
    assign bus.RESULT_VALID = (r_state == ST_REPORT);
    assign bus.TIMEOUT      = r_timeout;
    assign bus.CAP_C1X      = r_c1.x;
    assign bus.CAP_C1Y      = r_c1.y;
    assign bus.CAP_C2X      = r_c2.x;
    assign bus.CAP_C2Y      = r_c2.y;

endmodule

// File: tb/tb_laser_pattern_driver.sv
// tb_laser_pattern_driver: directed bench for the pattern driver. A table of
// pattern/answer vectors is applied in a loop, followed by hand-written
// sequences for the timeout, mid-run reset and load-with-START cases.
module tb_laser_pattern_driver;

`ifdef LASER_DRV_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    localparam int NPTS    = 40;
    localparam int TO_CYC  = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    laser_pattern_driver_if bus ();

    laser_pattern_driver #(
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] ax, ay, bx, by;      // even points = A, odd points = B
        logic [3:0] c1x, c1y, c2x, c2y;  // engine answer
        int         n;                   // covered count with scoring enabled
    } vec_t;

    vec_t       vecs [7];
    logic [3:0] exp_x [NPTS];
    logic [3:0] exp_y [NPTS];

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic load_pt(input int a, input logic [3:0] x, input logic [3:0] y);
        bus.LD_VALID = 1'b1;
        bus.LD_ADDR  = 6'(a);
        bus.LD_X     = x;
        bus.LD_Y     = y;
        tick();
        bus.LD_VALID = 1'b0;
        exp_x[a] = x;
        exp_y[a] = y;
    endtask

    // One full run with a well-behaved engine: DONE stale-high through SEND
    // and WAIT cycle 0, low in WAIT cycle 1, high with the answer in cycle 2.
    task automatic run_pattern(input string tag,
                               input logic [3:0] c1x, input logic [3:0] c1y,
                               input logic [3:0] c2x, input logic [3:0] c2y,
                               input int exp_n, input bit ld0,
                               input logic [3:0] ld0x, input logic [3:0] ld0y);
        int waited;
        int want_n;
        want_n = SCORE_ON ? exp_n : 0;
        bus.DONE = 1'b1;
        bus.C1X = ~c1x; bus.C1Y = ~c1y; bus.C2X = ~c2x; bus.C2Y = ~c2y;
        bus.START = 1'b1;
        if (ld0) begin
            bus.LD_VALID = 1'b1;
            bus.LD_ADDR  = 6'd0;
            bus.LD_X     = ld0x;
            bus.LD_Y     = ld0y;
            exp_x[0] = ld0x;
            exp_y[0] = ld0y;
        end
        tick();
        bus.START = 1'b0;
        bus.LD_VALID = 1'b0;
        check({tag, " busy@send0"}, int'(bus.BUSY), 1);
        check({tag, " timeout cleared"}, int'(bus.TIMEOUT), 0);
        check({tag, " cnt cleared"}, int'(bus.COVER_CNT), 0);
        for (int k = 0; k < NPTS; k++) begin
            check($sformatf("%s x[%0d]", tag, k), int'(bus.X), int'(exp_x[k]));
            check($sformatf("%s y[%0d]", tag, k), int'(bus.Y), int'(exp_y[k]));
            if (k == 10) begin
                // both must be ignored while busy
                bus.START    = 1'b1;
                bus.LD_VALID = 1'b1;
                bus.LD_ADDR  = 6'd30;
                bus.LD_X     = ~exp_x[30];
                bus.LD_Y     = ~exp_y[30];
            end else begin
                bus.START    = 1'b0;
                bus.LD_VALID = 1'b0;
            end
            tick();
        end
        // WAIT cycle 0, DONE still stale-high
        check({tag, " x@wait"}, int'(bus.X), 0);
        check({tag, " y@wait"}, int'(bus.Y), 0);
        tick();
        // WAIT cycle 1: stale DONE must not have been taken
        check({tag, " rv@wait1"}, int'(bus.RESULT_VALID), 0);
        check({tag, " busy@wait1"}, int'(bus.BUSY), 1);
        bus.DONE = 1'b0;
        tick();
        bus.DONE = 1'b1;
        bus.C1X = c1x; bus.C1Y = c1y; bus.C2X = c2x; bus.C2Y = c2y;
        tick();
        bus.C1X = ~c1x; bus.C1Y = ~c1y; bus.C2X = ~c2x; bus.C2Y = ~c2y;
        waited = 0;
        while (!bus.RESULT_VALID && waited < 100) begin
            tick();
            waited++;
        end
        check({tag, " score latency"}, waited, SCORE_ON ? NPTS : 0);
        check({tag, " rv"}, int'(bus.RESULT_VALID), 1);
        check({tag, " cover"}, int'(bus.COVER_CNT), want_n);
        check({tag, " c1x"}, int'(bus.CAP_C1X), int'(c1x));
        check({tag, " c1y"}, int'(bus.CAP_C1Y), int'(c1y));
        check({tag, " c2x"}, int'(bus.CAP_C2X), int'(c2x));
        check({tag, " c2y"}, int'(bus.CAP_C2Y), int'(c2y));
        check({tag, " timeout"}, int'(bus.TIMEOUT), 0);
        $display("run %s: cover=%0d cap=(%0d,%0d)/(%0d,%0d)", tag, bus.COVER_CNT,
                 bus.CAP_C1X, bus.CAP_C1Y, bus.CAP_C2X, bus.CAP_C2Y);
        tick();
        check({tag, " rv pulse"}, int'(bus.RESULT_VALID), 0);
        check({tag, " idle"}, int'(bus.BUSY), 0);
        check({tag, " cover hold"}, int'(bus.COVER_CNT), want_n);
    endtask

    initial begin
        int waited;
        vecs[0] = '{ax: 3, ay: 3,  bx: 3,  by: 3,  c1x: 3,  c1y: 3, c2x: 12, c2y: 12, n: 40};
        vecs[1] = '{ax: 0, ay: 0,  bx: 15, by: 15, c1x: 2,  c1y: 2, c2x: 9,  c2y: 9,  n: 20};
        vecs[2] = '{ax: 7, ay: 3,  bx: 8,  by: 3,  c1x: 3,  c1y: 3, c2x: 15, c2y: 15, n: 20};
        vecs[3] = '{ax: 0, ay: 4,  bx: 0,  by: 5,  c1x: 0,  c1y: 0, c2x: 15, c2y: 15, n: 20};
        vecs[4] = '{ax: 0, ay: 0,  bx: 0,  by: 0,  c1x: 15, c1y: 6, c2x: 15, c2y: 6,  n: 0};
        vecs[5] = '{ax: 8, ay: 3,  bx: 12, by: 12, c1x: 3,  c1y: 3, c2x: 12, c2y: 12, n: 20};
        vecs[6] = '{ax: 5, ay: 5,  bx: 5,  by: 5,  c1x: 5,  c1y: 5, c2x: 6,  c2y: 6,  n: 40};

        rst = 1'b1;
        bus.LD_VALID = 1'b0; bus.LD_ADDR = '0; bus.LD_X = '0; bus.LD_Y = '0;
        bus.START = 1'b0; bus.DONE = 1'b1;
        bus.C1X = '0; bus.C1Y = '0; bus.C2X = '0; bus.C2Y = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst x", int'(bus.X), 0);
        check("rst y", int'(bus.Y), 0);
        check("rst busy", int'(bus.BUSY), 0);
        check("rst rv", int'(bus.RESULT_VALID), 0);
        check("rst cnt", int'(bus.COVER_CNT), 0);
        check("rst timeout", int'(bus.TIMEOUT), 0);
        check("rst c1x", int'(bus.CAP_C1X), 0);
        check("rst c2y", int'(bus.CAP_C2Y), 0);

        for (int v = 0; v < 7; v++) begin
            for (int p = 0; p < NPTS; p++) begin
                if (p % 2 == 0) load_pt(p, vecs[v].ax, vecs[v].ay);
                else            load_pt(p, vecs[v].bx, vecs[v].by);
            end
            run_pattern($sformatf("v%0d", v), vecs[v].c1x, vecs[v].c1y,
                        vecs[v].c2x, vecs[v].c2y, vecs[v].n, 1'b0, 4'd0, 4'd0);
        end

        // load of point 0 in the START cycle; (15,0) is outside both circles
        run_pattern("ld0", 4'd5, 4'd5, 4'd6, 4'd6, 39, 1'b1, 4'd15, 4'd0);

        // engine never drops DONE: timeout after TO_CYC WAIT cycles
        bus.DONE = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        waited = 1;
        while (!bus.RESULT_VALID && waited < 400) begin
            tick();
            waited++;
        end
        check("to latency", waited, 1 + NPTS + TO_CYC);
        check("to rv", int'(bus.RESULT_VALID), 1);
        check("to flag", int'(bus.TIMEOUT), 1);
        check("to cnt", int'(bus.COVER_CNT), 0);
        $display("run timeout: timeout=%0d cover=%0d", bus.TIMEOUT, bus.COVER_CNT);
        tick();
        check("to sticky", int'(bus.TIMEOUT), 1);
        check("to idle", int'(bus.BUSY), 0);

        // next START clears the sticky flag
        run_pattern("after_to", 4'd5, 4'd5, 4'd6, 4'd6, 39, 1'b0, 4'd0, 4'd0);

        // reset on the 20th SEND cycle
        bus.DONE = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        repeat (19) tick();
        check("rstrun x19", int'(bus.X), int'(exp_x[19]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstrun x", int'(bus.X), 0);
        check("rstrun y", int'(bus.Y), 0);
        check("rstrun busy", int'(bus.BUSY), 0);
        check("rstrun rv", int'(bus.RESULT_VALID), 0);
        check("rstrun c1x", int'(bus.CAP_C1X), 0);
        check("rstrun c2x", int'(bus.CAP_C2X), 0);
        tick();
        check("rstrun stays idle", int'(bus.BUSY), 0);
        $display("run midreset: busy=%0d x=%0d y=%0d", bus.BUSY, bus.X, bus.Y);

        // rerun without reload: pattern memory survived the reset
        run_pattern("rerun", 4'd5, 4'd5, 4'd6, 4'd6, 39, 1'b0, 4'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
